// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter
//
// Round-robin arbiter and sequencer for one shared prescaled counter.
// Each requester asks for a timed run of N counter ticks. The winner is granted,
// the counter is cleared for one cycle, and counting is then enabled until Q
// equals the latched target. Completion is signalled with a one-cycle done pulse.
// A run is cancelled (abort pulse) if the owner drops its request early.
// This block is the counter's only driver.
//
// Optional build macro: COUNTER_RUN_ARBITER_TIMEOUT_EN
//   Adds a per-run watchdog. A run that spends TIMEOUT_CYCLES cycles in RUN is
//   aborted, and the sticky timeout_err output is set until clear.
//
// Ports:
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   req          per-requester run request (level, held until done/abort)
//   target       per-requester tick count, slice i = [i*WIDTH +: WIDTH]
//   grant        one-hot owner of the counter (CLR..DONE/ABORT)
//   done         one-hot, one-cycle pulse on run completion
//   abort        one-hot, one-cycle pulse on run cancellation
//   busy         high in any state other than IDLE
//   cnt_clear    counter clear (also high while clear is high)
//   cnt_count    counter count enable
//   cnt_q        counter Q
//   timeout_err  sticky watchdog flag (only with COUNTER_RUN_ARBITER_TIMEOUT_EN)

module counter_run_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   target,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         abort,
    output logic                       busy,
    output logic                       cnt_clear,
    output logic                       cnt_count,
    input  logic [WIDTH-1:0]           cnt_q
`ifdef COUNTER_RUN_ARBITER_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("counter_run_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [WIDTH-1:0]   tgt, tgt_n;
    logic [NUM_REQ-1:0] owner;
    logic [IDX_W-1:0]   pick;
    logic               own_req;
    logic               wd_hit;

    // First set request at or above ptr, wrapping past NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               c;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && r[c[IDX_W-1:0]]) begin
                sel   = c[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [NUM_REQ*WIDTH-1:0] t,
                                                  input logic [IDX_W-1:0]         i);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i == IDX_W'(k)) s = t[k*WIDTH +: WIDTH];
        end
        return s;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign pick    = rr_pick(req, rr_ptr);
    assign owner   = NUM_REQ'(1) << idx;
    assign own_req = req[idx];

`ifdef COUNTER_RUN_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd;
    logic            wd_fire;

    // wd holds the number of RUN cycles already spent; the hit fires in the
    // TIMEOUT_CYCLES-th RUN cycle so RUN lasts exactly TIMEOUT_CYCLES cycles.
    assign wd_hit  = (wd + WD_W'(1)) == WD_W'(TIMEOUT_CYCLES);
    // Only a watchdog-caused abort sets the sticky flag; a dropped request or
    // a simultaneous target match takes precedence.
    assign wd_fire = (state == S_RUN) && own_req && (cnt_q != tgt) && wd_hit;

    always_ff @(posedge clock) begin
        if (clear) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_CLR) begin
                wd <= '0;
            end else if (state == S_RUN) begin
                wd <= wd + WD_W'(1);
            end
            if (wd_fire) timeout_err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        tgt <= tgt_n;
        if (clear) begin
            state  <= S_IDLE;
            idx    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    // Next state plus Moore outputs decoded from the registered state; only
    // cnt_clear also follows the clear input directly so the counter resets
    // together with this block.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        rr_ptr_n  = rr_ptr;
        tgt_n     = tgt;
        grant     = '0;
        done      = '0;
        abort     = '0;
        busy      = 1'b1;
        cnt_clear = clear;
        cnt_count = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    idx_n   = pick;
                    tgt_n   = slice_of(target, pick);
                    state_n = S_CLR;
                end
            end
            S_CLR: begin
                grant     = owner;
                cnt_clear = 1'b1;
                if (!own_req) begin
                    state_n = S_ABORT;
                end else if (tgt == '0) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                grant     = owner;
                cnt_count = 1'b1;
                if (!own_req) begin
                    state_n = S_ABORT;
                end else if (cnt_q == tgt) begin
                    state_n = S_DONE;
                end else if (wd_hit) begin
                    state_n = S_ABORT;
                end
            end
            S_DONE: begin
                grant    = owner;
                done     = owner;
                rr_ptr_n = next_ptr(idx);
                state_n  = S_IDLE;
            end
            S_ABORT: begin
                grant    = owner;
                abort    = owner;
                rr_ptr_n = next_ptr(idx);
                state_n  = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
